fisc_uart_tx: RTL

Memory-mapped serial transmit port on the FISC CPU's output side. The CPU writes bytes with a one-cycle strobe, and each byte lands in a small synchronous FIFO. A baud-rate FSM serialises the FIFO contents as 8N1 frames on `txd`. The bench's console monitor samples `txd`, which gives programs a byte output path besides PC-based termination.

---
 rtl/fisc_uart_tx_pkg.sv | 14 +
 rtl/fisc_uart_tx_if.sv | 26 ++
 rtl/fisc_sync_fifo.sv | 55 +++++
 rtl/fisc_uart_tx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fisc_uart_tx_pkg.sv
// Shared definitions for the FISC serial transmit port: FSM state encodings and 8N1 frame geometry.
package fisc_uart_tx_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/fisc_uart_tx_if.sv
// CPU-side bus of the transmit port: write strobe/data in, FIFO and line status out.
interface fisc_uart_tx_if
  import fisc_uart_tx_pkg::*;
#(
  parameter int WordSize = DATA_BITS
);

  logic [WordSize-1:0] wdata;
  logic                wr;
  logic                full;
  logic                empty;
  logic                busy;
  logic                overflow;
  logic                txd;

  modport master (
    output wdata, wr,
    input  full, empty, busy, overflow, txd
  );

  modport slave (
    input  wdata, wr,
    output full, empty, busy, overflow, txd
  );

endinterface

// File: rtl/fisc_sync_fifo.sv
// Synchronous FIFO with combinational read data at the read pointer and flags decoded from the registered count.
module fisc_sync_fifo #(
  parameter  int Width = 8,
  parameter  int Depth = 8,
  localparam int AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AddrW:0]   count
);

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [AddrW:0]   r_count;

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == (AddrW + 1)'(Depth));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/fisc_uart_tx.sv
// Memory-mapped 8N1 transmitter: CPU writes land in a FIFO, a baud-rate FSM serialises them on txd.
module fisc_uart_tx
  import fisc_uart_tx_pkg::*;
#(
  parameter int WordSize  = 8,
  parameter int ClkDiv    = 16,
  parameter int FifoDepth = 8
) (
  input  logic           clk,
  input  logic           reset,
  fisc_uart_tx_if.slave  bus
);

  localparam int BaudW  = $clog2(ClkDiv);
  localparam int CountW = $clog2(FifoDepth) + 1;
  localparam logic [BaudW-1:0] BaudReload = BaudW'(ClkDiv - 1);
  localparam logic [2:0]       LastBit    = 3'(DATA_BITS - 1);

  tx_state_e           r_state;
  tx_state_e           w_state_next;
  logic [BaudW-1:0]    r_baud;
  logic [BaudW-1:0]    w_baud_next;
  logic [2:0]          r_bit;
  logic [2:0]          w_bit_next;
  logic [WordSize-1:0] r_shift;
  logic [WordSize-1:0] w_shift_next;
  logic                r_txd;
  logic                w_txd_next;
  logic                r_overflow;

  logic                w_push;
  logic                w_pop;
  logic [WordSize-1:0] w_fifo_dout;
  logic                w_full;
  logic                w_empty;
  logic [CountW-1:0]   w_count;

  // A write into a full FIFO still fits when the FSM pops in the same cycle.
  assign w_push = bus.wr && ((w_count < CountW'(FifoDepth)) || w_pop);

  fisc_sync_fifo #(
    .Width (WordSize),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.wdata),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_txd   <= w_txd_next;
      if (bus.wr && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // txd is registered from the level the next state will drive, so it changes on the same edge as the state.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_txd_next   = 1'b1;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_fifo_dout;
          w_baud_next  = BaudReload;
          w_state_next = ST_START;
          w_txd_next   = 1'b0;
        end
      end
      ST_START: begin
        w_txd_next = 1'b0;
        if (r_baud == '0) begin
          w_baud_next  = BaudReload;
          w_bit_next   = '0;
          w_state_next = ST_DATA;
          w_txd_next   = r_shift[0];
        end else begin
          w_baud_next = r_baud - 1'b1;
        end
      end
      ST_DATA: begin
        w_txd_next = r_shift[0];
        if (r_baud == '0) begin
          w_baud_next  = BaudReload;
          w_shift_next = r_shift >> 1;
          if (r_bit == LastBit) begin
            w_state_next = ST_STOP;
            w_txd_next   = 1'b1;
          end else begin
            w_bit_next = r_bit + 1'b1;
            w_txd_next = r_shift[1];
          end
        end else begin
          w_baud_next = r_baud - 1'b1;
        end
      end
      ST_STOP: begin
        w_txd_next = 1'b1;
        if (r_baud == '0) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_fifo_dout;
            w_baud_next  = BaudReload;
            w_state_next = ST_START;
            w_txd_next   = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_baud_next = r_baud - 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.txd      = r_txd;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.overflow = r_overflow;

endmodule
